// File: rtl/l2_out_arb.sv
// l2_out_arb: merges L2 rsp/fwd/req channels onto one NoC port via a 1-entry output register.
// Optional counters: define L2_OUT_ARB_STATS_EN.
module l2_out_arb #(
    parameter int MSG_W      = 5,
    parameter int ADDR_W     = 28,
    parameter int LINE_W     = 128,
    parameter int WMASK_W    = 4,
    parameter int ID_W       = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rsp_valid,
    output logic               rsp_ready,
    input  logic [MSG_W-1:0]   rsp_coh_msg,
    input  logic [ID_W-1:0]    rsp_req_id,
    input  logic [1:0]         rsp_to_req,
    input  logic [ADDR_W-1:0]  rsp_addr,
    input  logic [LINE_W-1:0]  rsp_line,
    input  logic [WMASK_W-1:0] rsp_word_mask,
    input  logic               fwd_valid,
    output logic               fwd_ready,
    input  logic [MSG_W-1:0]   fwd_coh_msg,
    input  logic [ID_W-1:0]    fwd_req_id,
    input  logic [1:0]         fwd_to_req,
    input  logic [ADDR_W-1:0]  fwd_addr,
    input  logic [LINE_W-1:0]  fwd_line,
    input  logic [WMASK_W-1:0] fwd_word_mask,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [MSG_W-1:0]   req_coh_msg,
    input  logic [1:0]         req_hprot,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [LINE_W-1:0]  req_line,
    input  logic [WMASK_W-1:0] req_word_mask,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         out_src,
    output logic [MSG_W-1:0]   out_coh_msg,
    output logic [ID_W-1:0]    out_req_id,
    output logic [1:0]         out_to_req,
    output logic [1:0]         out_hprot,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [LINE_W-1:0]  out_line,
`ifdef L2_OUT_ARB_STATS_EN
    output logic [WMASK_W-1:0] out_word_mask,
    output logic [15:0]        stat_rsp_cnt,
    output logic [15:0]        stat_fwd_cnt,
    output logic [15:0]        stat_req_cnt,
    output logic [15:0]        stat_stall_cnt
`else
    output logic [WMASK_W-1:0] out_word_mask
`endif
);

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t             state_q, state_d;
    logic [1:0]         src_q, src_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [1:0]         to_q, to_d;
    logic [1:0]         hprot_q, hprot_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  line_q, line_d;
    logic [WMASK_W-1:0] mask_q, mask_d;
    logic [7:0]         starve_q, starve_d;
    logic               load_ok;
    logic               gnt_rsp, gnt_fwd, gnt_req;

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        msg_d    = msg_q;
        id_d     = id_q;
        to_d     = to_q;
        hprot_d  = hprot_q;
        addr_d   = addr_q;
        line_d   = line_q;
        mask_d   = mask_q;
        starve_d = starve_q;
        gnt_rsp  = 1'b0;
        gnt_fwd  = 1'b0;
        gnt_req  = 1'b0;
        load_ok  = (state_q == S_EMPTY) || out_ready;

        // Readies stay low while reset is held
        if (!rst && load_ok) begin
            if (starve_q == STARVE_LIM && req_valid) gnt_req = 1'b1;
            else if (rsp_valid)                      gnt_rsp = 1'b1;
            else if (fwd_valid)                      gnt_fwd = 1'b1;
            else if (req_valid)                      gnt_req = 1'b1;
        end

        if (gnt_rsp) begin
            state_d = S_FULL;
            src_d   = 2'd0;
            msg_d   = rsp_coh_msg;
            id_d    = rsp_req_id;
            to_d    = rsp_to_req;
            hprot_d = 2'd0;
            addr_d  = rsp_addr;
            line_d  = rsp_line;
            mask_d  = rsp_word_mask;
        end else if (gnt_fwd) begin
            state_d = S_FULL;
            src_d   = 2'd1;
            msg_d   = fwd_coh_msg;
            id_d    = fwd_req_id;
            to_d    = fwd_to_req;
            hprot_d = 2'd0;
            addr_d  = fwd_addr;
            line_d  = fwd_line;
            mask_d  = fwd_word_mask;
        end else if (gnt_req) begin
            state_d = S_FULL;
            src_d   = 2'd2;
            msg_d   = req_coh_msg;
            id_d    = '0;
            to_d    = 2'd0;
            hprot_d = req_hprot;
            addr_d  = req_addr;
            line_d  = req_line;
            mask_d  = req_word_mask;
        end else if (state_q == S_FULL && out_ready) begin
            state_d = S_EMPTY;
        end

        // A NoC stall (load_ok low) is not counted as a lost round
        if (gnt_req)
            starve_d = 8'd0;
        else if (req_valid && load_ok && starve_q != STARVE_LIM)
            starve_d = starve_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            src_q    <= 2'd0;
            msg_q    <= '0;
            id_q     <= '0;
            to_q     <= 2'd0;
            hprot_q  <= 2'd0;
            addr_q   <= '0;
            line_q   <= '0;
            mask_q   <= '0;
            starve_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            msg_q    <= msg_d;
            id_q     <= id_d;
            to_q     <= to_d;
            hprot_q  <= hprot_d;
            addr_q   <= addr_d;
            line_q   <= line_d;
            mask_q   <= mask_d;
            starve_q <= starve_d;
        end
    end

    assign rsp_ready     = gnt_rsp;
    assign fwd_ready     = gnt_fwd;
    assign req_ready     = gnt_req;
    assign out_valid     = (state_q == S_FULL);
    assign out_src       = src_q;
    assign out_coh_msg   = msg_q;
    assign out_req_id    = id_q;
    assign out_to_req    = to_q;
    assign out_hprot     = hprot_q;
    assign out_addr      = addr_q;
    assign out_line      = line_q;
    assign out_word_mask = mask_q;

`ifdef L2_OUT_ARB_STATS_EN
    logic [15:0] st_rsp_q, st_fwd_q, st_req_q, st_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rsp_q   <= 16'd0;
            st_fwd_q   <= 16'd0;
            st_req_q   <= 16'd0;
            st_stall_q <= 16'd0;
        end else begin
            if (gnt_rsp) st_rsp_q <= st_rsp_q + 16'd1;
            if (gnt_fwd) st_fwd_q <= st_fwd_q + 16'd1;
            if (gnt_req) st_req_q <= st_req_q + 16'd1;
            if (state_q == S_FULL && !out_ready)
                st_stall_q <= st_stall_q + 16'd1;
        end
    end

    assign stat_rsp_cnt   = st_rsp_q;
    assign stat_fwd_cnt   = st_fwd_q;
    assign stat_req_cnt   = st_req_q;
    assign stat_stall_cnt = st_stall_q;
`endif

endmodule
